// File: rtl/mips16_pkg.sv
// Shared widths and encodings for the 16-bit MIPS datapath.
// The memory stage uses the access-direction and result-select codes.
package mips16_pkg;

  localparam int DATA_W    = 16;
  localparam int DM_ADDR_W = 6;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_MEM = 1'b1;

endpackage

// File: rtl/data_memory_stage_if.sv
// EX -> DM -> WB signal bundle for the memory-access stage.
// Valid/ready: none. Every field is valid on every cycle and consumed at every rising edge (no stall, no backpressure).
interface data_memory_stage_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] ans_ex;
  logic [DATA_W-1:0] DM_data;
  logic              mem_rw_ex;
  logic              mem_en_ex;
  logic              mem_mux_sel_dm;
  logic [DATA_W-1:0] ans_dm;

  modport master (
    output ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm,
    input  ans_dm
  );

  modport slave (
    input  ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm,
    output ans_dm
  );
endinterface

// File: rtl/dm_ram.sv
// Single-port data RAM: combinational read, synchronous write, async active-low clear of every word.
module dm_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read sees the pre-edge contents, giving read-before-write on a store cycle.
  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_stage.sv
// Memory-access pipeline stage: optional load/store on a word-addressed RAM, then a registered
// select between the loaded word and the ALU pass-through result.
module data_memory_stage #(
  parameter int DATA_W = mips16_pkg::DATA_W,
  parameter int ADDR_W = mips16_pkg::DM_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  data_memory_stage_if.slave  dm
);
  import mips16_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] mdata;
  logic [DATA_W-1:0] result;

  // Upper address bits are dropped on purpose: addresses alias modulo the RAM depth.
  assign addr = dm.ans_ex[ADDR_W-1:0];
  assign we   = dm.mem_en_ex && (dm.mem_rw_ex == MEM_WRITE);

  dm_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .wdata (dm.DM_data),
    .rdata (rdata)
  );

  always_comb begin
    mdata  = '0;
    result = dm.ans_ex;
    if (dm.mem_en_ex) begin
      mdata = rdata;
    end
    if (dm.mem_mux_sel_dm != SEL_ALU) begin
      result = mdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dm.ans_dm <= '0;
    end else begin
      dm.ans_dm <= result;
    end
  end

endmodule

// File: tb/tb_data_memory_stage.sv
// Bench for data_memory_stage: directed vector table, async-reset corner sequence,
// then random traffic checked against a behavioural RAM model.
module tb_data_memory_stage;
  import mips16_pkg::*;

  localparam int W  = 16;
  localparam int AW = 6;

  logic clk;
  logic reset;

  data_memory_stage_if #(.DATA_W(W)) dm_if ();

  data_memory_stage #(
    .DATA_W (W),
    .ADDR_W (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dm    (dm_if)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] model_mem [2**AW];

  typedef struct {
    logic         en;
    logic         rw;
    logic         sel;
    logic [W-1:0] ans;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic en, logic rw, logic sel, logic [W-1:0] ans,
                              logic [W-1:0] data, logic [W-1:0] exp);
    vec_t v;
    v.en = en; v.rw = rw; v.sel = sel; v.ans = ans; v.data = data; v.exp = exp;
    return v;
  endfunction

  task automatic check_out(input string name);
    logic [W-1:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, ans_dm=%h", name, dm_if.ans_dm);
    end else begin
      e = exp_q.pop_front();
      if (dm_if.ans_dm !== e) begin
        n_bad++;
        $display("FAIL %s: ans_dm=%h expected=%h", name, dm_if.ans_dm, e);
      end
    end
  endtask

  // Driver: apply inputs after the falling edge, check #1 after the next rising edge.
  task automatic drive(input logic en, input logic rw, input logic sel,
                       input logic [W-1:0] ans, input logic [W-1:0] data);
    @(negedge clk);
    dm_if.mem_en_ex      = en;
    dm_if.mem_rw_ex      = rw;
    dm_if.mem_mux_sel_dm = sel;
    dm_if.ans_ex         = ans;
    dm_if.DM_data        = data;
  endtask

  task automatic step_vec(input vec_t v, input string name);
    drive(v.en, v.rw, v.sel, v.ans, v.data);
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic step_model(input logic en, input logic rw, input logic sel,
                            input logic [W-1:0] ans, input logic [W-1:0] data);
    logic [W-1:0] md;
    logic [AW-1:0] a;
    drive(en, rw, sel, ans, data);
    a  = ans[AW-1:0];
    md = en ? model_mem[a] : '0;
    exp_q.push_back(sel ? md : ans);
    if (en && rw) model_mem[a] = data;
    @(posedge clk);
    #1;
    check_out("random");
  endtask

  initial begin
    vecs[0]  = mk(1, MEM_READ,  SEL_MEM, 16'h0003, 16'h0000, 16'h0000); // empty load
    vecs[1]  = mk(1, MEM_WRITE, SEL_MEM, 16'h0003, 16'hFFFF, 16'h0000); // store returns old
    vecs[2]  = mk(1, MEM_READ,  SEL_MEM, 16'h0003, 16'h0000, 16'hFFFF); // load new data
    vecs[3]  = mk(0, MEM_READ,  SEL_ALU, 16'h1234, 16'h0000, 16'h1234); // pass-through
    vecs[4]  = mk(0, MEM_WRITE, SEL_MEM, 16'h0003, 16'h0000, 16'h0000); // gated store
    vecs[5]  = mk(1, MEM_READ,  SEL_MEM, 16'h0003, 16'h0000, 16'hFFFF); // RAM unchanged
    vecs[6]  = mk(1, MEM_WRITE, SEL_ALU, 16'h0043, 16'hA5A5, 16'h0043); // aliased store
    vecs[7]  = mk(1, MEM_READ,  SEL_MEM, 16'h0003, 16'h0000, 16'hA5A5); // wrap load
    vecs[8]  = mk(1, MEM_WRITE, SEL_MEM, 16'h003F, 16'h1111, 16'h0000);
    vecs[9]  = mk(1, MEM_WRITE, SEL_MEM, 16'h003F, 16'h2222, 16'h1111); // back-to-back store
    vecs[10] = mk(1, MEM_READ,  SEL_MEM, 16'hFFFF, 16'h0000, 16'h2222); // last write wins
    vecs[11] = mk(1, MEM_READ,  SEL_ALU, 16'h8000, 16'h0000, 16'h8000);
    vecs[12] = mk(1, MEM_READ,  SEL_MEM, 16'h0000, 16'h0000, 16'h0000);

    reset                = 1'b0;
    dm_if.ans_ex         = 16'h0003;
    dm_if.DM_data        = '0;
    dm_if.mem_rw_ex      = MEM_READ;
    dm_if.mem_en_ex      = 1'b0;
    dm_if.mem_mux_sel_dm = SEL_ALU;

    // Reset held across an edge, then released.
    exp_q.push_back(16'h0000);
    @(posedge clk);
    #1;
    check_out("reset_hold");
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(16'h0003);
    @(posedge clk);
    #1;
    check_out("reset_release");

    foreach (vecs[i]) step_vec(vecs[i], $sformatf("vec%0d", i));

    // Store BEEF, then pulse reset between edges.
    drive(1, MEM_WRITE, SEL_ALU, 16'h0005, 16'hBEEF);
    exp_q.push_back(16'h0005);
    @(posedge clk);
    #1;
    check_out("store_beef");
    drive(1, MEM_READ, SEL_MEM, 16'h0005, 16'h0000);
    #1;
    reset = 1'b0;
    #1;
    exp_q.push_back(16'h0000);
    check_out("async_reset_now");
    #2;
    reset = 1'b1;
    exp_q.push_back(16'h0000);
    @(posedge clk);
    #1;
    check_out("load_after_reset");

    // Random traffic against the model; RAM was just cleared.
    foreach (model_mem[i]) model_mem[i] = '0;
    for (int k = 0; k < 400; k++) begin
      step_model(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 65535) & ((k % 3 == 0) ? 16'hFFFF : 16'h000F)),
                 16'($urandom_range(0, 65535)));
    end

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: queue size=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
